// File: rtl/bcd_pkg.sv
// Shared constants, converter state encoding and elaboration helpers for the
// BCD scan sequencer.
package bcd_pkg;

  localparam logic [4:0] BLANK_CODE = 5'b1_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } conv_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  // ceil(bin_width * log10(2)) in fixed point, valid for practical widths
  function automatic int unsigned min_digits(input int unsigned bin_width);
    return (bin_width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Sequential shift-and-add-3 binary to BCD converter with start/busy/done
// handshake; one bit is consumed per clock.
module bcd_dabble_core
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 8,
  parameter int unsigned NDIGITS   = 3
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [BIN_WIDTH-1:0]   bin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   bcd
);

  localparam int unsigned BW = 4 * NDIGITS;
  localparam int unsigned CW = clog2(BIN_WIDTH + 1);

  conv_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]        scratch_q, scratch_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [BW-1:0]        adj_c;
  logic [BW-1:0]        stepped_c;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    adj_c     = scratch_q;

    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    stepped_c = {adj_c[BW-2:0], shift_q[BIN_WIDTH-1]};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        scratch_d = stepped_c;
        shift_d   = shift_q << 1;
        cnt_d     = CW'(cnt_q + 1'b1);
        // Result lands in the visible register together with the done pulse
        if (cnt_q == CW'(BIN_WIDTH - 1)) begin
          bcd_d   = stepped_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/bcd_scan_sequencer.sv
// Captures a binary switch word, converts it to BCD and scans the digits out
// to a seven-segment multiplexer with leading-zero blanking and decimal point.
module bcd_scan_sequencer
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 8,
  parameter int unsigned NDIGITS   = 3,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter bit          BLANK_LZ  = 1'b1,
  parameter int unsigned DP_POS    = 0,
  localparam int unsigned DIGW     = clog2(NDIGITS + 1)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 BTND,
  input  logic [BIN_WIDTH-1:0] SW,
  output logic [BIN_WIDTH-1:0] bindata,
  output logic [4:0]           data,
  output logic [DIGW-1:0]      digit,
  output logic                 setdp,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? clog2(SCAN_DIV) : 1;

  if (NDIGITS < min_digits(BIN_WIDTH)) begin : g_ndigits_too_small
    $error("bcd_scan_sequencer: NDIGITS too small for BIN_WIDTH");
  end

  logic [4*NDIGITS-1:0] bcd_w;
  logic                 accept_c;
  logic [BIN_WIDTH-1:0] bindata_q, bindata_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [DIGW-1:0]      ptr_q, ptr_d;
  logic [DIGW-1:0]      digit_q, digit_d;
  logic [4:0]           data_q, data_d;
  logic                 setdp_q, setdp_d;
  logic                 wrap_c;
  logic [DIGW-1:0]      sel_c;
  logic [NDIGITS-1:0]   lead_zero_c;
  logic                 run_c;

  // The core only samples start in IDLE, where neither busy nor done is high
  assign accept_c = BTND && !busy && !done;

  bcd_dabble_core #(
    .BIN_WIDTH (BIN_WIDTH),
    .NDIGITS   (NDIGITS)
  ) u_core (
    .clock  (clock),
    .resetn (resetn),
    .start  (BTND),
    .bin    (SW),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd_w)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bindata_q <= '0;
      presc_q   <= '0;
      ptr_q     <= DIGW'(NDIGITS);
      digit_q   <= '0;
      data_q    <= '0;
      setdp_q   <= 1'b0;
    end else begin
      bindata_q <= bindata_d;
      presc_q   <= presc_d;
      ptr_q     <= ptr_d;
      digit_q   <= digit_d;
      data_q    <= data_d;
      setdp_q   <= setdp_d;
    end
  end

  always_comb begin
    bindata_d   = accept_c ? SW : bindata_q;
    wrap_c      = (presc_q == PW'(SCAN_DIV - 1));
    presc_d     = wrap_c ? '0 : PW'(presc_q + 1'b1);
    ptr_d       = ptr_q;
    if (wrap_c) ptr_d = (ptr_q == DIGW'(1)) ? DIGW'(NDIGITS) : DIGW'(ptr_q - 1'b1);
    // Digit shown in the coming cycle; data keeps refreshing so a new result shows at once
    sel_c       = wrap_c ? ptr_q : digit_q;
    digit_d     = sel_c;
    data_d      = '0;
    setdp_d     = 1'b0;
    lead_zero_c = '0;
    run_c       = 1'b1;

    for (int k = int'(NDIGITS); k >= 1; k--) begin
      run_c            = run_c && (bcd_w[4*(k-1) +: 4] == 4'd0);
      lead_zero_c[k-1] = run_c;
    end

    for (int k = 1; k <= int'(NDIGITS); k++) begin
      if (sel_c == DIGW'(k)) begin
        setdp_d = (k == int'(DP_POS));
        if (BLANK_LZ && (k != 1) && (k != int'(DP_POS)) && lead_zero_c[k-1]) begin
          data_d = BLANK_CODE;
        end else begin
          data_d = {1'b0, bcd_w[4*(k-1) +: 4]};
        end
      end
    end
  end

  assign bindata = bindata_q;
  assign digit   = digit_q;
  assign data    = data_q;
  assign setdp   = setdp_q;

endmodule

// File: tb/tb_bcd_scan_sequencer.sv
// Directed bench for bcd_scan_sequencer: three parameterisations share clock
// and reset; conversion timing, scan order, blanking and DP are checked.
module tb_bcd_scan_sequencer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        btnd_v [3];
  logic [11:0] sw_v   [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic        dp_v   [3];
  logic [4:0]  data_v [3];
  logic [2:0]  dig_v  [3];
  logic [11:0] bin_v  [3];

  logic [7:0]  bin_a, bin_b;
  logic [11:0] bin_c;
  logic [1:0]  dig_a, dig_b;
  logic [2:0]  dig_c;

  int n_checks = 0;
  int n_errors = 0;

  bcd_scan_sequencer #(.BIN_WIDTH(8), .NDIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1'b1), .DP_POS(0)) u_a (
    .clock(clk), .resetn(resetn), .BTND(btnd_v[0]), .SW(sw_v[0][7:0]), .bindata(bin_a),
    .data(data_v[0]), .digit(dig_a), .setdp(dp_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  bcd_scan_sequencer #(.BIN_WIDTH(8), .NDIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1'b0), .DP_POS(2)) u_b (
    .clock(clk), .resetn(resetn), .BTND(btnd_v[1]), .SW(sw_v[1][7:0]), .bindata(bin_b),
    .data(data_v[1]), .digit(dig_b), .setdp(dp_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  bcd_scan_sequencer #(.BIN_WIDTH(12), .NDIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1'b1), .DP_POS(0)) u_c (
    .clock(clk), .resetn(resetn), .BTND(btnd_v[2]), .SW(sw_v[2]), .bindata(bin_c),
    .data(data_v[2]), .digit(dig_c), .setdp(dp_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  assign bin_v[0] = 12'(bin_a);
  assign bin_v[1] = 12'(bin_b);
  assign bin_v[2] = bin_c;
  assign dig_v[0] = 3'(dig_a);
  assign dig_v[1] = 3'(dig_b);
  assign dig_v[2] = dig_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input int sel, input string tag);
    chk({tag, " busy"},    32'(busy_v[sel]), 32'd0);
    chk({tag, " done"},    32'(done_v[sel]), 32'd0);
    chk({tag, " data"},    32'(data_v[sel]), 32'd0);
    chk({tag, " digit"},   32'(dig_v[sel]),  32'd0);
    chk({tag, " setdp"},   32'(dp_v[sel]),   32'd0);
    chk({tag, " bindata"}, 32'(bin_v[sel]),  32'd0);
  endtask

  // Press for one edge, then check busy/done cycle by cycle; an optional
  // second press is injected at CONV cycle glitch_k+1.
  task automatic convert(input int sel, input logic [11:0] sw, input int bw,
                         input int glitch_k, input logic [11:0] glitch_sw, input string tag);
    @(negedge clk);
    sw_v[sel]   = sw;
    btnd_v[sel] = 1'b1;
    @(negedge clk);
    btnd_v[sel] = 1'b0;
    for (int k = 0; k < bw; k++) begin
      if (k == glitch_k) begin
        sw_v[sel]   = glitch_sw;
        btnd_v[sel] = 1'b1;
      end else begin
        btnd_v[sel] = 1'b0;
      end
      chk({tag, " busy in conv"}, 32'(busy_v[sel]), 32'd1);
      chk({tag, " done in conv"}, 32'(done_v[sel]), 32'd0);
      @(negedge clk);
    end
    btnd_v[sel] = 1'b0;
    chk({tag, " done pulse"},  32'(done_v[sel]), 32'd1);
    chk({tag, " busy at done"}, 32'(busy_v[sel]), 32'd0);
    chk({tag, " bindata"},     32'(bin_v[sel]),  32'(sw));
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'(done_v[sel]), 32'd0);
  endtask

  // Align to the start of the top digit, then check nd digits held 4 clocks each.
  task automatic scan(input int sel, input int nd, input logic [19:0] exp_data,
                      input logic [3:0] exp_dp, input string tag);
    logic [2:0] prev;
    int guard;
    bit synced;
    guard  = 0;
    synced = 1'b0;
    @(negedge clk);
    prev = dig_v[sel];
    while (!synced && guard < 100) begin
      @(negedge clk);
      if (dig_v[sel] == 3'(nd) && prev != 3'(nd)) synced = 1'b1;
      prev = dig_v[sel];
      guard++;
    end
    chk({tag, " scan sync"}, 32'(synced), 32'd1);
    for (int d = nd; d >= 1; d--) begin
      for (int c = 0; c < 4; c++) begin
        chk({tag, " digit"}, 32'(dig_v[sel]),  32'(d));
        chk({tag, " data"},  32'(data_v[sel]), 32'(exp_data[5*d-1 -: 5]));
        chk({tag, " setdp"}, 32'(dp_v[sel]),   32'(exp_dp[d-1]));
        @(negedge clk);
      end
    end
    chk({tag, " wrap to top"}, 32'(dig_v[sel]), 32'(nd));
  endtask

  initial begin
    bit saw_done;
    for (int i = 0; i < 3; i++) begin
      btnd_v[i] = 1'b0;
      sw_v[i]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle_outputs(i, "reset");
    resetn = 1'b1;
    @(negedge clk);
    chk("digit before first wrap", 32'(dig_v[0]), 32'd0);

    convert(0, 12'h0FF, 8, -1, '0, "A ff");
    scan(0, 3, {5'h00, 5'h02, 5'h05, 5'h05}, 4'b0000, "A ff");

    convert(0, 12'd7, 8, -1, '0, "A 7");
    scan(0, 3, {5'h00, 5'h10, 5'h10, 5'h07}, 4'b0000, "A 7 blank");

    convert(1, 12'd0, 8, -1, '0, "B 0");
    scan(1, 3, {5'h00, 5'h00, 5'h00, 5'h00}, 4'b0010, "B 0 dp");

    convert(0, 12'd200, 8, 2, 12'd9, "A 200 glitch");
    scan(0, 3, {5'h00, 5'h02, 5'h00, 5'h00}, 4'b0000, "A 200");
    convert(0, 12'd9, 8, -1, '0, "A 9");
    scan(0, 3, {5'h00, 5'h10, 5'h10, 5'h09}, 4'b0000, "A 9 blank");

    // Abort a conversion with a one-cycle reset pulse
    @(negedge clk);
    sw_v[0]   = 12'd99;
    btnd_v[0] = 1'b1;
    @(negedge clk);
    btnd_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy before reset", 32'(busy_v[0]), 32'd1);
    resetn = 1'b0;
    #1;
    check_idle_outputs(0, "abort");
    @(negedge clk);
    resetn = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) saw_done = 1'b1;
    end
    chk("abort no done", 32'(saw_done), 32'd0);
    convert(0, 12'd128, 8, -1, '0, "A 128");
    scan(0, 3, {5'h00, 5'h01, 5'h02, 5'h08}, 4'b0000, "A 128");

    convert(2, 12'hFFF, 12, -1, '0, "C fff");
    scan(2, 4, {5'h04, 5'h00, 5'h09, 5'h05}, 4'b0000, "C fff");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
